// File: rtl/spi_inst_pkg.sv
// Shared constants for the SPI instruction sequencer:
// opcodes, FSM state encodings and data widths.
package spi_inst_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    localparam logic [7:0] OP_EN      = 8'h01;
    localparam logic [7:0] OP_REG_WR  = 8'h02;
    localparam logic [7:0] OP_REG_RD  = 8'h03;
    localparam logic [7:0] OP_FIFO_WR = 8'h04;
    localparam logic [7:0] OP_FIFO_RD = 8'h05;
    localparam logic [7:0] OP_RAM_WR  = 8'h06;
    localparam logic [7:0] OP_RAM_RD  = 8'h07;

    // Each state names the byte expected next
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_REG_ADDR = 4'd1;
    localparam logic [3:0] S_REG_HI   = 4'd2;
    localparam logic [3:0] S_REG_LO   = 4'd3;
    localparam logic [3:0] S_RAM_ADDR = 4'd4;
    localparam logic [3:0] S_LEN_HI   = 4'd5;
    localparam logic [3:0] S_LEN_LO   = 4'd6;
    localparam logic [3:0] S_DATA_HI  = 4'd7;
    localparam logic [3:0] S_DATA_LO  = 4'd8;

endpackage

// File: rtl/spi_inst_sequencer_if.sv
// Byte stream from the SPI slave plus the register, FIFO and RAM ports.
interface spi_inst_sequencer_if #(
    parameter int DEPTH_W = 8
);
    import spi_inst_pkg::*;

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic [BYTE_W-1:0] tx_byte;
    logic              enabled;
    logic              reg_we;
    logic [BYTE_W-1:0] reg_addr;
    logic [WORD_W-1:0] reg_wdata;
    logic [WORD_W-1:0] reg_rdata;
    logic              fifo_wr_en;
    logic [WORD_W-1:0] fifo_wdata;
    logic              fifo_full;
    logic              fifo_rd_en;
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_empty;
    logic              ram_we;
    logic [DEPTH_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    modport master (
        input  rx_valid, rx_byte, reg_rdata, fifo_full,
        input  fifo_rdata, fifo_empty, ram_rdata,
        output tx_byte, enabled, reg_we, reg_addr, reg_wdata,
        output fifo_wr_en, fifo_wdata, fifo_rd_en,
        output ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output rx_valid, rx_byte, reg_rdata, fifo_full,
        output fifo_rdata, fifo_empty, ram_rdata,
        input  tx_byte, enabled, reg_we, reg_addr, reg_wdata,
        input  fifo_wr_en, fifo_wdata, fifo_rd_en,
        input  ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/spi_inst_sequencer.sv
// Parses the SPI command byte stream, drives register/FIFO/RAM strobes
// and stages the reply byte for the next SPI byte slot.
module spi_inst_sequencer
    import spi_inst_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input logic clk,
    input logic rst,
    spi_inst_sequencer_if.master bus
);
    localparam int OFF_W = DEPTH_W + 1;

    logic [3:0]         state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic               enabled_q, enabled_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [OFF_W-1:0]   off_q, off_d, off_inc;
    logic [7:0]         hi_q, hi_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         tx_q, tx_d;
    logic               fetch_q, fetch_d, fetch_ok_q, fetch_ok_d;
    logic               cap_q, cap_d, cap_ok_q, cap_ok_d;
    logic               reg_we_q, reg_we_d;
    logic [7:0]         reg_addr_q, reg_addr_d;
    logic [15:0]        reg_wdata_q, reg_wdata_d;
    logic               fifo_wr_en_q, fifo_wr_en_d;
    logic [15:0]        fifo_wdata_q, fifo_wdata_d;
    logic               fifo_rd_en_q, fifo_rd_en_d;
    logic               ram_we_q, ram_we_d;
    logic [DEPTH_W-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]        ram_wdata_q, ram_wdata_d;
    logic [15:0]        len;
    logic [15:0]        src;
    logic               pf_req;
    logic               rd_op;

    // Bit DEPTH_W is sticky so a long burst never wraps back into range
    assign off_inc = off_q[DEPTH_W] ? off_q : off_q + OFF_W'(1);
    assign rd_op   = (op_q == OP_FIFO_RD) || (op_q == OP_RAM_RD);
    assign src     = (op_q == OP_REG_RD)  ? bus.reg_rdata  :
                     (op_q == OP_FIFO_RD) ? bus.fifo_rdata : bus.ram_rdata;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        enabled_d    = enabled_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        tx_d         = tx_q;
        fetch_d      = 1'b0;
        fetch_ok_d   = 1'b0;
        cap_d        = fetch_q;
        cap_ok_d     = fetch_ok_q;
        reg_we_d     = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        fifo_wr_en_d = 1'b0;
        fifo_wdata_d = fifo_wdata_q;
        fifo_rd_en_d = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        len          = {cnt_q[7:0], bus.rx_byte};
        pf_req       = 1'b0;

        // Fetched word lands two cycles after the prefetch decision
        if (cap_q) begin
            tx_d = cap_ok_q ? src[15:8] : 8'h00;
            lo_d = cap_ok_q ? src[7:0]  : 8'h00;
        end

        if (bus.rx_valid) begin
            tx_d = 8'h00;
            case (state_q)
                S_IDLE: begin
                    op_d = bus.rx_byte;
                    if (bus.rx_byte == OP_EN) begin
                        enabled_d = 1'b1;
                    end else if (enabled_q) begin
                        case (bus.rx_byte)
                            OP_REG_WR, OP_REG_RD:   state_d = S_REG_ADDR;
                            OP_FIFO_WR, OP_FIFO_RD: state_d = S_LEN_HI;
                            OP_RAM_WR, OP_RAM_RD:   state_d = S_RAM_ADDR;
                            default:                state_d = S_IDLE;
                        endcase
                    end
                end
                S_REG_ADDR: begin
                    reg_addr_d = bus.rx_byte;
                    state_d    = S_REG_HI;
                    if (op_q == OP_REG_RD) begin
                        fetch_d    = 1'b1;
                        fetch_ok_d = 1'b1;
                    end
                end
                S_REG_HI: begin
                    hi_d    = bus.rx_byte;
                    state_d = S_REG_LO;
                    if (op_q == OP_REG_RD) tx_d = lo_q;
                end
                S_REG_LO: begin
                    state_d = S_IDLE;
                    if (op_q == OP_REG_WR) begin
                        reg_we_d    = 1'b1;
                        reg_wdata_d = {hi_q, bus.rx_byte};
                    end
                end
                S_RAM_ADDR: begin
                    off_d   = OFF_W'(bus.rx_byte);
                    state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    cnt_d   = {8'h00, bus.rx_byte};
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    cnt_d   = len;
                    state_d = (len == 16'd0) ? S_IDLE : S_DATA_HI;
                    pf_req  = (len != 16'd0);
                end
                S_DATA_HI: begin
                    hi_d    = bus.rx_byte;
                    state_d = S_DATA_LO;
                    if (rd_op) tx_d = lo_q;
                end
                S_DATA_LO: begin
                    cnt_d   = cnt_q - 16'd1;
                    state_d = (cnt_q == 16'd1) ? S_IDLE : S_DATA_HI;
                    pf_req  = (cnt_q != 16'd1);
                    if (op_q == OP_FIFO_WR && !bus.fifo_full) begin
                        fifo_wr_en_d = 1'b1;
                        fifo_wdata_d = {hi_q, bus.rx_byte};
                    end
                    if (op_q == OP_RAM_WR) begin
                        ram_we_d    = !off_q[DEPTH_W];
                        ram_addr_d  = off_q[DEPTH_W-1:0];
                        ram_wdata_d = {hi_q, bus.rx_byte};
                        off_d       = off_inc;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (pf_req && op_q == OP_FIFO_RD) begin
                fetch_d      = 1'b1;
                fetch_ok_d   = !bus.fifo_empty;
                fifo_rd_en_d = !bus.fifo_empty;
            end
            if (pf_req && op_q == OP_RAM_RD) begin
                fetch_d    = 1'b1;
                fetch_ok_d = !off_q[DEPTH_W];
                ram_addr_d = off_q[DEPTH_W-1:0];
                off_d      = off_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            enabled_q    <= 1'b0;
            cnt_q        <= '0;
            off_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            tx_q         <= '0;
            fetch_q      <= 1'b0;
            fetch_ok_q   <= 1'b0;
            cap_q        <= 1'b0;
            cap_ok_q     <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            fifo_wr_en_q <= 1'b0;
            fifo_wdata_q <= '0;
            fifo_rd_en_q <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            enabled_q    <= enabled_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            tx_q         <= tx_d;
            fetch_q      <= fetch_d;
            fetch_ok_q   <= fetch_ok_d;
            cap_q        <= cap_d;
            cap_ok_q     <= cap_ok_d;
            reg_we_q     <= reg_we_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_wdata_q <= fifo_wdata_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign bus.tx_byte    = tx_q;
    assign bus.enabled    = enabled_q;
    assign bus.reg_we     = reg_we_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_wdata  = reg_wdata_q;
    assign bus.fifo_wr_en = fifo_wr_en_q;
    assign bus.fifo_wdata = fifo_wdata_q;
    assign bus.fifo_rd_en = fifo_rd_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_spi_inst_sequencer.sv
// Scoreboard bench: reply bytes and resource strobes are checked against
// expectations queued as each command byte is driven.
module tb_spi_inst_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_inst_sequencer_if #(.DEPTH_W(8)) bus ();

    spi_inst_sequencer #(.DEPTH_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_push = 0;
    int n_pop = 0;
    int n_ramw = 0;
    int fmodel = 0;

    logic [7:0]  sb_tx[$];
    logic [23:0] sb_reg[$];
    logic [15:0] sb_fifo[$];
    logic [23:0] sb_ram[$];

    logic [15:0] regs [256];
    logic [15:0] mem [256];
    logic [15:0] fq[$];
    int          fcnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Resource models
    assign bus.reg_rdata  = regs[bus.reg_addr];
    assign bus.fifo_full  = (fcnt >= 256);
    assign bus.fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (bus.reg_we) regs[bus.reg_addr] <= bus.reg_wdata;
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.fifo_wr_en && fq.size() < 256) fq.push_back(bus.fifo_wdata);
        if (bus.fifo_rd_en && fq.size() > 0) bus.fifo_rdata <= fq.pop_front();
        fcnt <= fq.size();
    end

    // Strobe monitor
    always @(negedge clk) begin
        logic [3:0]  stb;
        logic [31:0] exp;
        if (!rst) begin
            stb = {bus.reg_we, bus.fifo_wr_en, bus.fifo_rd_en, bus.ram_we};
            if (|stb) check("strobe_onehot", 32'($countones(stb)), 32'd1);
            if (bus.reg_we) begin
                exp = sb_reg.size() > 0 ? 32'(sb_reg.pop_front()) : 32'h1000000;
                check("reg_wr", {8'h0, bus.reg_addr, bus.reg_wdata}, exp);
            end
            if (bus.fifo_wr_en) begin
                n_push++;
                exp = sb_fifo.size() > 0 ? 32'(sb_fifo.pop_front()) : 32'h10000;
                check("fifo_wr", {16'h0, bus.fifo_wdata}, exp);
            end
            if (bus.ram_we) begin
                n_ramw++;
                exp = sb_ram.size() > 0 ? 32'(sb_ram.pop_front()) : 32'h1000000;
                check("ram_wr", {8'h0, bus.ram_addr, bus.ram_wdata}, exp);
            end
            if (bus.fifo_rd_en) n_pop++;
        end
    end

    task automatic send(input logic [7:0] b, input logic [7:0] exp_tx);
        @(posedge clk);
        #1;
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        sb_tx.push_back(exp_tx);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("tx_byte", 32'(bus.tx_byte), 32'(sb_tx.pop_front()));
        repeat (9) @(posedge clk);
    endtask

    function automatic logic [15:0] exp_word(input bit ram, input int a,
                                             input int i);
        if (ram) return (a + i < 256) ? 16'(2000 + a + i) : 16'h0000;
        return (i < 256) ? 16'(1000 + i) : 16'h0000;
    endfunction

    task automatic stream(input logic [7:0] op, input int a, input int n,
                          input int base);
        bit ram;
        bit rd;
        logic [15:0] w;
        logic [15:0] wn;
        ram = (op == 8'h06) || (op == 8'h07);
        rd  = (op == 8'h05) || (op == 8'h07);
        send(op, 8'h00);
        if (ram) send(8'(a), 8'h00);
        send(8'(n >> 8), 8'h00);
        w = (rd && n > 0) ? exp_word(ram, a, 0) : 16'h0000;
        send(8'(n), w[15:8]);
        for (int i = 0; i < n; i++) begin
            if (rd) begin
                wn = (i < n - 1) ? exp_word(ram, a, i + 1) : 16'h0000;
                send(8'h00, w[7:0]);
                send(8'h00, wn[15:8]);
                w = wn;
            end else begin
                w = 16'(base + i);
                send(w[15:8], 8'h00);
                if (ram) begin
                    if (a + i < 256) sb_ram.push_back({8'(a + i), w});
                end else if (fmodel < 256) begin
                    sb_fifo.push_back(w);
                    fmodel++;
                end
                send(w[7:0], 8'h00);
            end
        end
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
        send(8'h02, 8'h00);
        send(a, 8'h00);
        send(d[15:8], 8'h00);
        sb_reg.push_back({a, d});
        send(d[7:0], 8'h00);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 90000 cycles");
        $fatal(1);
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", 32'(bus.tx_byte), 32'h0);
        check("rst_enabled", 32'(bus.enabled), 32'h0);
        check("rst_strobes", {28'h0, bus.reg_we, bus.fifo_wr_en,
              bus.fifo_rd_en, bus.ram_we}, 32'h0);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'h0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);

        // Commands before enable are one-byte no-ops
        send(8'h02, 8'h00);
        send(8'h07, 8'h00);
        check("still_disabled", 32'(bus.enabled), 32'h0);
        send(8'h01, 8'h00);
        check("enabled", 32'(bus.enabled), 32'h1);
        send(8'h5A, 8'h00);

        reg_wr(8'h01, 16'h1234);
        reg_wr(8'h00, 16'hBEEF);

        send(8'h03, 8'h00);
        send(8'h00, 8'hBE);
        send(8'h00, 8'hEF);
        send(8'h00, 8'h00);

        // Zero-length burst returns to IDLE right after NL
        stream(8'h04, 0, 0, 0);
        reg_wr(8'h07, 16'hABCD);

        stream(8'h04, 0, 300, 1000);
        stream(8'h05, 0, 300, 0);
        stream(8'h06, 0, 300, 2000);
        stream(8'h07, 0, 300, 0);
        stream(8'h07, 254, 3, 0);

        // Reset in the middle of a register write
        send(8'h02, 8'h00);
        send(8'h09, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_enabled", 32'(bus.enabled), 32'h0);
        send(8'h01, 8'h00);
        check("midrst_reenabled", 32'(bus.enabled), 32'h1);
        reg_wr(8'h05, 16'hAABB);

        repeat (20) @(posedge clk);
        check("fifo_pushes", 32'(n_push), 32'd256);
        check("fifo_pops", 32'(n_pop), 32'd256);
        check("ram_writes", 32'(n_ramw), 32'd256);
        check("sb_left", 32'(sb_reg.size() + sb_fifo.size() + sb_ram.size()),
              32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
